// File: rtl/fir_mac_sequencer.sv
// +----------------------------------------------------------------------------+
// | fir_mac_sequencer: time-multiplexed FIR, one tap per cycle through an       |
// | external saturating multiplier, saturating accumulate.                      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_mac_sequencer #(
  parameter int Width = 16,
  parameter int f     = 10,
  parameter int p     = 5,
  parameter int Taps  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [Width-1:0]   in_data,
  output logic                      in_ready,
  input  logic                      coef_we,
  input  logic [$clog2(Taps)-1:0]   coef_addr,
  input  logic signed [Width-1:0]   coef_data,
  output logic signed [Width-1:0]   mult_a,
  output logic signed [Width-1:0]   mult_b,
  input  logic signed [Width-1:0]   mult_y,
  output logic                      out_valid,
  output logic signed [Width-1:0]   out_data
);

  localparam int c_aw = $clog2(Taps);

  if ((p + f + 1 != Width) || (Taps < 2) || (Taps > 64) || ((Taps & (Taps - 1)) != 0))
  begin : g_param_check
    $error("fir_mac_sequencer: illegal parameterisation");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_t;

  state_t                   r_state;
  logic [c_aw-1:0]          r_k;
  logic [c_aw-1:0]          r_wr_ptr;
  logic signed [Width-1:0]  r_acc;
  logic signed [Width-1:0]  r_delay [Taps];
  logic signed [Width-1:0]  r_coef  [Taps];

  logic [c_aw-1:0]          w_next_k;
  logic [c_aw-1:0]          w_rd_idx;
  logic                     w_last;
  logic signed [Width-1:0]  w_sum;
  logic signed [Width-1:0]  w_coef0;

  // Overflow is only possible when both addends share a sign; clamp each step.
  function automatic logic signed [Width-1:0] satadd(input logic signed [Width-1:0] a,
                                                     input logic signed [Width-1:0] b);
    logic signed [Width-1:0] s;
    s = a + b;
    if ((a[Width-1] == b[Width-1]) && (s[Width-1] != a[Width-1]))
      s = a[Width-1] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    return s;
  endfunction

  assign w_next_k = r_k + c_aw'(1);
  assign w_rd_idx = r_wr_ptr - w_next_k;
  assign w_last   = (r_k == c_aw'(Taps - 1));
  assign w_sum    = satadd(r_acc, mult_y);
  // A coefficient written on the acceptance edge must already feed tap 0.
  assign w_coef0  = (coef_we && (coef_addr == '0)) ? coef_data : r_coef[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      in_ready  <= 1'b1;
      r_k       <= '0;
      r_wr_ptr  <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
      for (int i = 0; i < Taps; i++) begin
        r_delay[i] <= '0;
        r_coef[i]  <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (coef_we)
            r_coef[coef_addr] <= coef_data;
          if (in_valid) begin
            r_delay[r_wr_ptr] <= in_data;
            r_k      <= '0;
            r_acc    <= '0;
            mult_a   <= in_data;
            mult_b   <= w_coef0;
            in_ready <= 1'b0;
            r_state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_sum;
          r_k   <= w_next_k;
          if (w_last) begin
            out_data  <= w_sum;
            out_valid <= 1'b1;
            r_wr_ptr  <= r_wr_ptr + c_aw'(1);
            mult_a    <= '0;
            mult_b    <= '0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            mult_a <= r_delay[w_rd_idx];
            mult_b <= r_coef[w_next_k];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_fir_mac_sequencer: directed scoreboard bench for fir_mac_sequencer.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fir_mac_sequencer;

  localparam int W    = 16;
  localparam int TAPS = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic signed [W-1:0]   in_data;
  logic                  in_ready;
  logic                  coef_we;
  logic [2:0]            coef_addr;
  logic signed [W-1:0]   coef_data;
  logic signed [W-1:0]   mult_a;
  logic signed [W-1:0]   mult_b;
  logic signed [W-1:0]   mult_y;
  logic                  out_valid;
  logic signed [W-1:0]   out_data;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic signed [31:0] prod;
  logic signed [31:0] prod_sh;

  fir_mac_sequencer #(.Width(W), .f(10), .p(5), .Taps(TAPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_y    (mult_y),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Q5.10 saturating multiplier model
  always_comb begin
    prod    = mult_a * mult_b;
    prod_sh = prod >>> 10;
    if (prod_sh > 32'sd32767)       mult_y = 16'sh7FFF;
    else if (prod_sh < -32'sd32768) mult_y = 16'sh8000;
    else                            mult_y = prod_sh[15:0];
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out_valid: out_data=%h with no result pending", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", out_data, mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] e, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_total++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end else if (push) begin
      exp_q.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wcoef(input logic [2:0] a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    step();
    coef_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic load_ramp_coefs();
    for (int k = 0; k < TAPS; k++) wcoef(3'(k), 16'((k + 1) * 16'h0040));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    int accepted;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    rst_n     = 1'b0;
    repeat (2) step();
    chk("reset_in_ready", 16'(in_ready), 16'h0001);
    chk("reset_out_valid", 16'(out_valid), 16'h0000);
    chk("reset_out_data", out_data, 16'h0000);
    chk("reset_mult_a", mult_a, 16'h0000);
    chk("reset_mult_b", mult_b, 16'h0000);
    rst_n = 1'b1;
    step();

    // Impulse response through ramp coefficients
    load_ramp_coefs();
    send(16'h0400, 16'h0040, 1'b1);
    chk("mac_k0_mult_a", mult_a, 16'h0400);
    chk("mac_k0_mult_b", mult_b, 16'h0040);
    step();
    chk("mac_k1_mult_a", mult_a, 16'h0000);
    chk("mac_k1_mult_b", mult_b, 16'h0080);
    for (int i = 1; i < TAPS; i++) send(16'h0000, 16'((i + 1) * 16'h0040), 1'b1);
    drain();
    chk("idle_mult_a", mult_a, 16'h0000);
    chk("idle_mult_b", mult_b, 16'h0000);
    chk("idle_in_ready", 16'(in_ready), 16'h0001);

    // Positive saturation
    do_reset();
    for (int k = 0; k < TAPS; k++) wcoef(3'(k), 16'h7FFF);
    for (int i = 0; i < TAPS; i++) send(16'h7FFF, 16'h7FFF, 1'b1);
    drain();

    // Negative saturation
    do_reset();
    for (int k = 0; k < TAPS; k++) wcoef(3'(k), 16'h0400);
    for (int i = 0; i < TAPS; i++) send(16'h8000, 16'h8000, 1'b1);
    drain();

    // Continuous in_valid: busy windows of exactly TAPS cycles
    do_reset();
    wcoef(3'd0, 16'h0400);
    run      = 0;
    accepted = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0100 + i);
      if (in_ready === 1'b1) begin
        exp_q.push_back(16'(16'h0100 + i));
        if (accepted > 0) chk("busy_cycles", 16'(run), 16'(TAPS));
        run = 0;
        accepted++;
      end else begin
        run++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("accepted_count", 16'(accepted), 16'd4);
    drain();

    // Coefficient write while busy is ignored; in IDLE it is used
    send(16'h0200, 16'h0200, 1'b1);
    step();
    wcoef(3'd0, 16'h0800);
    drain();
    wcoef(3'd0, 16'h0800);
    send(16'h0100, 16'h0200, 1'b1);
    drain();

    // Coefficient write on the acceptance edge
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'h0C00;
    send(16'h0100, 16'h0300, 1'b1);
    coef_we   = 1'b0;
    drain();

    // Reset at k=3 aborts with no result
    load_ramp_coefs();
    send(16'h0400, 16'h0000, 1'b0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 16'(in_ready), 16'h0001);
    chk("abort_out_valid", 16'(out_valid), 16'h0000);
    chk("abort_mult_a", mult_a, 16'h0000);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    load_ramp_coefs();
    send(16'h0400, 16'h0040, 1'b1);
    for (int i = 1; i < TAPS; i++) send(16'h0000, 16'((i + 1) * 16'h0040), 1'b1);
    drain();

    // Coefficients cleared by reset
    do_reset();
    send(16'h0400, 16'h0000, 1'b1);
    drain();
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter Width, default 16, sample/coefficient/product word width, two's complement.
REQ-002 SHALL have parameter f, default 10, fractional bits (Q5.10 at defaults).
REQ-003 SHALL have parameter p, default 5, integer bits excluding sign.
REQ-004 SHALL have parameter Taps, default 8, filter length, power of two, 2..64.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1, new sample present.
REQ-008 SHALL have port in_data, input, Width, signed input sample.
REQ-009 SHALL have port in_ready, output, 1, sequencer can accept a sample.
REQ-010 SHALL have port coef_we, input, 1, coefficient write strobe.
REQ-011 SHALL have port coef_addr, input, clog2(Taps), coefficient index.
REQ-012 SHALL have port coef_data, input, Width, signed coefficient.
REQ-013 SHALL have port mult_a, output, Width, signed operand A to the saturating multiplier (delayed sample).
REQ-014 SHALL have port mult_b, output, Width, signed operand B to the saturating multiplier (coefficient).
REQ-015 SHALL have port mult_y, input, Width, signed saturated product, combinational from mult_a/mult_b in the same cycle.
REQ-016 SHALL have port out_valid, output, 1, one-cycle pulse, filtered sample ready.
REQ-017 SHALL have port out_data, output, Width, signed filtered sample, held until next result.

Function
REQ-018 SHALL implement FSM states IDLE and MAC; in_ready = 1 only in IDLE.
REQ-019 Sample SHALL be accepted on an edge with in_valid=1 and in_ready=1: in_data written to delay line at wr_ptr, tap counter k<=0, acc<=0, state->MAC.
REQ-020 in_valid while in_ready=0 SHALL be ignored (sample dropped, no state change).
REQ-021 In MAC cycle k (0..Taps-1), mult_a SHALL equal delay[(wr_ptr-k) mod Taps] and mult_b SHALL equal coef[k]; k=0 is newest sample.
REQ-022 In IDLE, mult_a and mult_b SHALL be 0.
REQ-023 Each MAC edge SHALL update acc <= satadd(acc, mult_y) and increment k.
REQ-024 satadd SHALL be Width-bit add; if both operands share sign and result sign differs, clamp to 0x7FFF (positive) or 0x8000 (negative) at Width=16; clamping applies per step.
REQ-025 On the edge ending k=Taps-1: out_data<=satadd(acc,mult_y), out_valid<=1 for one cycle, wr_ptr<=wr_ptr+1 mod Taps, state->IDLE.
REQ-026 Latency: out_valid SHALL be high in the cycle following the Taps-th edge after the acceptance edge; throughput one sample per Taps+1 cycles.
REQ-027 in_valid during the out_valid cycle SHALL be accepted (back-to-back operation).
REQ-028 Coefficient write SHALL take effect when coef_we=1 in IDLE; writes while in MAC SHALL be ignored.
REQ-029 Simultaneous coef_we and sample acceptance in IDLE SHALL both take effect; new coefficient used by that computation.
REQ-030 wr_ptr wrap SHALL be modulo Taps with no gap or duplicated tap.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, in_ready 1, k 0, wr_ptr 0, acc 0, all delay-line entries 0, all coefficients 0, out_valid 0, out_data 0, mult_a/mult_b 0.
REQ-032 Reset mid-MAC SHALL abort the computation with no out_valid pulse; operation resumes from clean state on the first edge after rst_n rises.

Verification
REQ-033 Impulse: coef[k]=(k+1)*0x0040, feed 0x0400 then seven 0x0000 -> out_data = 0x0040,0x0080,...,0x0200 on successive results.
REQ-034 Positive saturation: all coef=0x7FFF, eight samples 0x7FFF -> final out_data 0x7FFF, no wrap to negative.
REQ-035 Negative saturation: all coef=0x0400, eight samples 0x8000 -> out_data 0x8000.
REQ-036 Handshake: in_valid held high continuously -> in_ready low for exactly Taps cycles per sample, one out_valid per accepted sample, samples offered while busy dropped.
REQ-037 Coef write during MAC -> ignored; same write in IDLE -> used by next result.
REQ-038 rst_n asserted at k=3 -> out_valid stays 0, in_ready 1 immediately; next impulse reproduces REQ-033 results from zeroed delay line with coef all zero -> 0x0000.
